inst_queue: RTL and testbench
=============================

# inst_queue

Instruction queue between the fetch stage and decode/issue. Buffers fetched instructions with their PCs in a circular FIFO and presents the oldest entry to decode in first-word-fall-through form. Asserts an early-full signal back to fetch with enough slack to absorb in-flight memory returns. Discards all contents on a ROB-driven pipeline refresh.

## Interface
- `DEPTH`, 16: number of entries; power of two, ≥ 4.
- `SLACK`, 2: free entries still available when `iq_full_if_out` asserts; 1 ≤ SLACK < DEPTH.
- `INST_WIDTH`, 32: instruction width, from `define.vh`.
- `ADDR_WIDTH`, 32: PC width, from `define.vh`.

Ports:
- `clk_in`  in  1  clock; all state changes on the rising edge.
- `rst_in`  in  1  reset; synchronous, active-low.
- `rdy_in`  in  1  global enable; low freezes all state.
- `rdy_inst_if_in`  in  1  fetch presents a valid instruction this cycle (push request).
- `inst_if_in`  in  INST_WIDTH  instruction from fetch.
- `pc_if_in`  in  ADDR_WIDTH  PC of that instruction.
- `iq_full_if_out`  out  1  early-full to fetch; combinational from count.
- `rdy_inst_dec_out`  out  1  head entry valid.
- `inst_dec_out`  out  INST_WIDTH  head instruction.
- `pc_dec_out`  out  ADDR_WIDTH  head PC.
- `taken_dec_in`  in  1  decode consumes the head this cycle (pop).
- `refresh_rob_cdb_in`  in  1  flush request from ROB.
- `overflow_out`  out  1  sticky error: a push arrived while `count == DEPTH`.

## Operation
- State: storage arrays `inst_q[DEPTH]`, `pc_q[DEPTH]`; `head`, `tail` of log2(DEPTH) bits; `count` of log2(DEPTH)+1 bits.
- Pointers wrap modulo DEPTH by natural overflow. No wrap flag; full/empty are taken from `count` only.
- Push: `push = rdy_inst_if_in && count != DEPTH`. Writes `inst_q[tail]` and `pc_q[tail]`, then `tail <= tail + 1`.
- Pop: `pop = taken_dec_in && count != 0`. Sets `head <= head + 1`. `taken_dec_in` while empty is ignored.
- Count update: push only, +1; pop only, −1; both in the same cycle, unchanged.
- Push while `count == DEPTH`: the data is dropped, no state changes, and `overflow_out <= 1`. `overflow_out` clears only on reset.
- Outputs, first-word fall-through:
  - `rdy_inst_dec_out = (count != 0)`.
  - `inst_dec_out = inst_q[head]`, `pc_dec_out = pc_q[head]`.
- `iq_full_if_out = (count >= DEPTH − SLACK)`.
- Flush: when `refresh_rob_cdb_in` is high, `head`, `tail` and `count` go to 0. A push or pop in the same cycle is discarded. Array contents are not cleared. `overflow_out` is kept.
- Priority, per edge:
  1. Reset (`rst_in == 0`).
  2. `rdy_in == 0`: hold everything.
  3. Flush.
  4. Push/pop.

## Timing
- Reset values:
  - `head`, `tail`, `count` = 0; all array entries = 0.
  - `rdy_inst_dec_out` = 0, `inst_dec_out` = 0, `pc_dec_out` = 0, `iq_full_if_out` = 0, `overflow_out` = 0.
- Reset asserted mid-operation empties the queue on that edge, regardless of `rdy_in` or flush.
- Latency: an entry pushed at edge N appears at the head at edge N+1 when the queue was empty. There is no same-cycle bypass from `inst_if_in` to `inst_dec_out`.
- Throughput: one push and one pop per cycle, sustained.
- `iq_full_if_out` changes in the cycle after the `count` update, since it is combinational from the registered count.
- SLACK = 2 covers fetch's pipeline: the request is gated by the full signal, memory returns, and fetch registers the result one cycle later. That is at most two pushes after full asserts.
- A flush at edge N gives `rdy_inst_dec_out = 0` and `iq_full_if_out = 0` from N+1. A push at N+1 is accepted normally.
- `rdy_in` low: head outputs are held stable and `taken_dec_in` has no effect.

## Test plan
- Reset, then push PCs 0x0, 0x4, 0x8 on consecutive cycles with no pop → after the third edge, count = 3, head `pc_dec_out` = 0x0, `rdy_inst_dec_out` = 1. Then pop ×3 → PCs 0x0, 0x4, 0x8 come out in order, then `rdy_inst_dec_out` = 0.
- DEPTH = 16, SLACK = 2: push 14 entries → `iq_full_if_out` = 1 after the 14th edge. Push 2 more → count = 16, `overflow_out` = 0. Push a 17th → dropped, `overflow_out` = 1, count = 16.
- Wrap-around: repeat 40 cycles of simultaneous push and pop starting from count = 1 → count stays 1; the head PC always equals the PC pushed one cycle earlier; pointers wrap past 15 to 0.
- Flush with 5 entries, with push and pop asserted in the same cycle → next cycle count = 0, `rdy_inst_dec_out` = 0. The pushed instruction never appears. The next push at 0x100 becomes the head.
- `rdy_in` low for 3 cycles with push and pop asserted → count, head and outputs unchanged. After `rdy_in` returns high, operation resumes.
- Reset asserted (`rst_in` = 0) with a full queue and `overflow_out` = 1 → next cycle all outputs are 0 and count = 0.

Source files
------------

// File: rtl/inst_queue_if.sv
// inst_queue_if: fetch-side push and decode-side head/pop signals of the instruction queue
interface inst_queue_if #(
    parameter int INST_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  rdy_inst_if_in;
    logic [INST_WIDTH-1:0] inst_if_in;
    logic [ADDR_WIDTH-1:0] pc_if_in;
    logic                  iq_full_if_out;
    logic                  rdy_inst_dec_out;
    logic [INST_WIDTH-1:0] inst_dec_out;
    logic [ADDR_WIDTH-1:0] pc_dec_out;
    logic                  taken_dec_in;
    modport master (
        output rdy_inst_if_in, inst_if_in, pc_if_in, taken_dec_in,
        input  iq_full_if_out, rdy_inst_dec_out, inst_dec_out, pc_dec_out
    );
    modport slave (
        input  rdy_inst_if_in, inst_if_in, pc_if_in, taken_dec_in,
        output iq_full_if_out, rdy_inst_dec_out, inst_dec_out, pc_dec_out
    );
endinterface

// File: rtl/inst_queue.sv
// inst_queue: circular FWFT instruction/PC FIFO between fetch and decode with early-full, flush and sticky overflow
module inst_queue #(
    parameter int DEPTH      = 16,
    parameter int SLACK      = 2,
    parameter int INST_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         rdy_in,
    input  logic         refresh_rob_cdb_in,
    inst_queue_if.slave  q,
    output logic         overflow_out
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] L_HIGH = (AW+1)'(DEPTH - SLACK);

    logic [INST_WIDTH-1:0] r_inst_q [DEPTH];
    logic [ADDR_WIDTH-1:0] r_pc_q   [DEPTH];
    logic [AW-1:0]         r_head;
    logic [AW-1:0]         r_tail;
    logic [AW:0]           r_count;
    logic                  r_overflow;
    logic                  w_push;
    logic                  w_pop;

    assign w_push = q.rdy_inst_if_in && (r_count != L_FULL);
    assign w_pop  = q.taken_dec_in && (r_count != '0);

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_inst_q[i] <= '0;
                r_pc_q[i]   <= '0;
            end
        end else if (rdy_in) begin
            if (refresh_rob_cdb_in) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_inst_q[r_tail] <= q.inst_if_in;
                    r_pc_q[r_tail]   <= q.pc_if_in;
                    r_tail           <= r_tail + 1'b1;
                end
                if (w_pop)
                    r_head <= r_head + 1'b1;
                if (w_push && !w_pop)
                    r_count <= r_count + 1'b1;
                else if (!w_push && w_pop)
                    r_count <= r_count - 1'b1;
                // a push the full queue cannot take is lost; flag it until reset
                if (q.rdy_inst_if_in && r_count == L_FULL)
                    r_overflow <= 1'b1;
            end
        end
    end

    assign q.rdy_inst_dec_out = (r_count != '0);
    assign q.inst_dec_out     = r_inst_q[r_head];
    assign q.pc_dec_out       = r_pc_q[r_head];
    assign q.iq_full_if_out   = (r_count >= L_HIGH);
    assign overflow_out       = r_overflow;
endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: directed vector table plus fill/overflow, wrap and reset sequences for inst_queue
module tb_inst_queue;
    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;
    logic refresh_rob_cdb_in;
    logic overflow_out;
    int   n_checks = 0;
    int   n_fail   = 0;

    inst_queue_if #(.INST_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    inst_queue #(.DEPTH(16), .SLACK(2), .INST_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .rdy_in             (rdy_in),
        .refresh_rob_cdb_in (refresh_rob_cdb_in),
        .q                  (bus),
        .overflow_out       (overflow_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        bit        rst;
        bit        en;
        bit        push;
        bit        pop;
        bit        flush;
        logic [31:0] pc;
        bit        erdy;
        logic [31:0] epc;
        bit        efull;
        bit        eovf;
    } vec_t;

    vec_t tbl [23];

    function automatic logic [31:0] mk_inst(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input bit rst, input bit en, input bit push, input logic [31:0] pc,
                         input bit pop, input bit flush);
        rst_in             = rst;
        rdy_in             = en;
        bus.rdy_inst_if_in = push;
        bus.pc_if_in       = pc;
        bus.inst_if_in     = mk_inst(pc);
        bus.taken_dec_in   = pop;
        refresh_rob_cdb_in = flush;
        @(posedge clk_in);
        #1;
    endtask

    task automatic check_out(input string tag, input bit erdy, input logic [31:0] epc,
                             input bit chk_pc, input bit efull, input bit eovf);
        chk({tag, ".rdy"}, 32'(bus.rdy_inst_dec_out), 32'(erdy));
        chk({tag, ".full"}, 32'(bus.iq_full_if_out), 32'(efull));
        chk({tag, ".ovf"}, 32'(overflow_out), 32'(eovf));
        if (chk_pc) chk({tag, ".pc"}, bus.pc_dec_out, epc);
        if (chk_pc && erdy) chk({tag, ".inst"}, bus.inst_dec_out, mk_inst(epc));
    endtask

    initial begin
        tbl[0]  = '{0, 1, 0, 0, 0, 32'h0,   0, 32'h0,   0, 0};
        tbl[1]  = '{1, 1, 1, 0, 0, 32'h0,   1, 32'h0,   0, 0};
        tbl[2]  = '{1, 1, 1, 0, 0, 32'h4,   1, 32'h0,   0, 0};
        tbl[3]  = '{1, 1, 1, 0, 0, 32'h8,   1, 32'h0,   0, 0};
        tbl[4]  = '{1, 1, 0, 1, 0, 32'h0,   1, 32'h4,   0, 0};
        tbl[5]  = '{1, 1, 0, 1, 0, 32'h0,   1, 32'h8,   0, 0};
        tbl[6]  = '{1, 1, 0, 1, 0, 32'h0,   0, 32'h0,   0, 0};
        tbl[7]  = '{1, 1, 0, 1, 0, 32'h0,   0, 32'h0,   0, 0};
        tbl[8]  = '{1, 1, 1, 1, 0, 32'h10,  1, 32'h10,  0, 0};
        tbl[9]  = '{1, 1, 1, 1, 0, 32'h14,  1, 32'h14,  0, 0};
        tbl[10] = '{1, 0, 1, 1, 0, 32'h18,  1, 32'h14,  0, 0};
        tbl[11] = '{1, 0, 1, 1, 0, 32'h18,  1, 32'h14,  0, 0};
        tbl[12] = '{1, 0, 1, 1, 0, 32'h18,  1, 32'h14,  0, 0};
        tbl[13] = '{1, 1, 0, 1, 0, 32'h0,   0, 32'h0,   0, 0};
        tbl[14] = '{1, 1, 1, 0, 0, 32'h20,  1, 32'h20,  0, 0};
        tbl[15] = '{1, 1, 1, 0, 0, 32'h24,  1, 32'h20,  0, 0};
        tbl[16] = '{1, 1, 1, 0, 0, 32'h28,  1, 32'h20,  0, 0};
        tbl[17] = '{1, 1, 1, 0, 0, 32'h2C,  1, 32'h20,  0, 0};
        tbl[18] = '{1, 1, 1, 0, 0, 32'h30,  1, 32'h20,  0, 0};
        tbl[19] = '{1, 1, 1, 1, 1, 32'hEEC, 0, 32'h0,   0, 0};
        tbl[20] = '{1, 1, 1, 0, 0, 32'h100, 1, 32'h100, 0, 0};
        tbl[21] = '{1, 1, 1, 1, 0, 32'h104, 1, 32'h104, 0, 0};
        tbl[22] = '{1, 1, 0, 1, 0, 32'h0,   0, 32'h8,   0, 0};

        for (int i = 0; i < 23; i++) begin
            apply(tbl[i].rst, tbl[i].en, tbl[i].push, tbl[i].pc, tbl[i].pop, tbl[i].flush);
            check_out($sformatf("vec%0d", i), tbl[i].erdy, tbl[i].epc, 1'b1, tbl[i].efull, tbl[i].eovf);
        end

        for (int i = 0; i < 16; i++) begin
            apply(1, 1, 1, 32'h200 + 32'(4 * i), 0, 0);
            check_out($sformatf("fill%0d", i), 1, 32'h200, 1, (i + 1) >= 14, 0);
        end
        apply(1, 1, 1, 32'h2FC, 0, 0);
        check_out("over", 1, 32'h200, 1, 1, 1);
        for (int k = 1; k <= 16; k++) begin
            apply(1, 1, 0, 32'h0, 1, 0);
            check_out($sformatf("drain%0d", k), (16 - k) > 0, 32'h200 + 32'(4 * k), (16 - k) > 0,
                      (16 - k) >= 14, 1);
        end

        apply(1, 1, 1, 32'h400, 0, 0);
        check_out("wrap0", 1, 32'h400, 1, 0, 1);
        for (int i = 1; i <= 40; i++) begin
            apply(1, 1, 1, 32'h400 + 32'(4 * i), 1, 0);
            check_out($sformatf("wrap%0d", i), 1, 32'h400 + 32'(4 * i), 1, 0, 1);
        end

        for (int i = 0; i < 15; i++) begin
            apply(1, 1, 1, 32'h500 + 32'(4 * i), 0, 0);
            check_out($sformatf("refill%0d", i), 1, 32'h4A0, 1, (i + 2) >= 14, 1);
        end
        apply(1, 1, 1, 32'h5FC, 0, 0);
        check_out("over2", 1, 32'h4A0, 1, 1, 1);

        apply(0, 0, 1, 32'h6F0, 1, 1);
        check_out("rst", 0, 32'h0, 1, 0, 0);
        chk("rst.inst", bus.inst_dec_out, 32'h0);
        apply(1, 1, 1, 32'h300, 0, 0);
        check_out("post_rst", 1, 32'h300, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
